// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the matrix scan arbiter
//
// Purpose: FSM state encoding, layer count and the "nothing lit" output
// values used by matrix_scan_arbiter and its testbench.
package game_pkg;

  localparam int         NUM_LAYERS = 4;
  localparam logic [7:0] ROW_OFF    = 8'hFF;    // active-low rows: all LEDs off
  localparam logic [3:0] COL_OFF    = 4'b0000;  // no column driven

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SHOW  = 2'd2,
    BLANK = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker over four layers
//
// Purpose: returns the first eligible layer scanning ptr, ptr+1, ... mod 4.
// Ports:
//   eligible [3:0] in  : per-layer eligibility
//   ptr      [1:0] in  : index to start scanning from
//   found          out : at least one layer is eligible
//   idx      [1:0] out : chosen layer (only meaningful when found=1)
module rr_pick (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [7:0] doubled;
  logic [3:0] rotated;
  logic [1:0] offset;

  always_comb begin
    // Rotate so that bit 0 of 'rotated' is layer ptr; the lowest set bit
    // is then the distance from ptr to the winner.
    doubled = {eligible, eligible} >> ptr;
    rotated = doubled[3:0];
    found   = |rotated;
    offset  = 2'd0;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
    idx = ptr + offset;
  end

endmodule

// File: rtl/matrix_scan_arbiter.sv
// rtl/matrix_scan_arbiter.sv - round-robin time-slot arbiter for a 4-layer LED matrix
//
// Purpose: grants one requesting layer at a time, snapshots its column/row/
// colour data and drives it onto the matrix for DWELL_CYCLES, followed by a
// BLANK_CYCLES gap with everything off.
// Ports:
//   CLK                     in  : system clock (posedge)
//   Clear                   in  : synchronous active-high reset
//   enable                  in  : gate for issuing new grants
//   req       [3:0]         in  : per-layer request
//   col_bus   [15:0]        in  : layer i column code at [4i+3:4i] (valid 1xxx)
//   row_bus   [31:0]        in  : layer i active-low row pattern at [8i+7:8i]
//   rgb_bus   [11:0]        in  : layer i {R,G,B} enables at [3i+2:3i]
//   R/G/B_color [7:0]       out : active-low row drives
//   column    [3:0]         out : column select, 0000 = none
//   grant     [3:0]         out : one-hot granted layer during SHOW
//   wrap_pulse              out : one-cycle pulse when layer 3's slot ends
module matrix_scan_arbiter
  import game_pkg::*;
#(
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Clear,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [15:0] col_bus,
  input  logic [31:0] row_bus,
  input  logic [11:0] rgb_bus,
  output logic [7:0]  R_color,
  output logic [7:0]  G_color,
  output logic [7:0]  B_color,
  output logic [3:0]  column,
  output logic [3:0]  grant,
  output logic        wrap_pulse
);

  // Counters load "length - 1" on entry and the state exits when they hit 0.
  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);
  localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYCLES - 1);

  state_t      state, state_next;
  logic [1:0]  ptr;
  logic [15:0] dwell_cnt;
  logic [7:0]  blank_cnt;

  logic [1:0]  lat_idx;
  logic [3:0]  lat_col;
  logic [7:0]  lat_row;
  logic [2:0]  lat_rgb;

  logic [3:0]  eligible;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic [3:0]  rgb_base;

  // A layer with an invalid column code (MSB clear) is never eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eligible[i] = req[i] & col_bus[4*i+3];
    end
  end

  rr_pick u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // 3 * pick_idx without a multiplier.
  assign rgb_base = {2'b00, pick_idx} + {1'b0, pick_idx, 1'b0};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && (|eligible)) state_next = ARB;
      ARB:     state_next = pick_found ? SHOW : IDLE;
      SHOW:    if (dwell_cnt == 16'd0) state_next = BLANK;
      BLANK:   if (blank_cnt == 8'd0) state_next = enable ? ARB : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      dwell_cnt  <= 16'd0;
      blank_cnt  <= 8'd0;
      lat_idx    <= 2'd0;
      lat_col    <= COL_OFF;
      lat_row    <= ROW_OFF;
      lat_rgb    <= 3'b000;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      wrap_pulse <= 1'b0;
      case (state)
        ARB: begin
          // Snapshot the winner so later bus changes cannot disturb the slot.
          if (pick_found) begin
            lat_idx   <= pick_idx;
            lat_col   <= col_bus[{pick_idx, 2'b00} +: 4];
            lat_row   <= row_bus[{pick_idx, 3'b000} +: 8];
            lat_rgb   <= rgb_bus[rgb_base +: 3];
            dwell_cnt <= DWELL_LOAD;
          end
        end
        SHOW: begin
          if (dwell_cnt == 16'd0) begin
            ptr        <= lat_idx + 2'd1;
            wrap_pulse <= (lat_idx == 2'd3);
            blank_cnt  <= BLANK_LOAD;
          end else begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end
        end
        BLANK: begin
          if (blank_cnt != 8'd0) blank_cnt <= blank_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from state so SHOW data appears on its first cycle.
  always_comb begin
    column  = COL_OFF;
    R_color = ROW_OFF;
    G_color = ROW_OFF;
    B_color = ROW_OFF;
    grant   = 4'b0000;
    if (state == SHOW) begin
      column  = lat_col;
      R_color = lat_rgb[2] ? lat_row : ROW_OFF;
      G_color = lat_rgb[1] ? lat_row : ROW_OFF;
      B_color = lat_rgb[0] ? lat_row : ROW_OFF;
      grant   = 4'b0001 << lat_idx;
    end
  end

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// tb/tb_matrix_scan_arbiter.sv - scoreboard testbench for matrix_scan_arbiter
module tb_matrix_scan_arbiter;

  localparam int DWELL = 4;
  localparam int BLANK = 1;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] column;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } slot_t;

  logic        clk;
  logic        clear;
  logic        enable;
  logic [3:0]  req;
  logic [15:0] col_bus;
  logic [31:0] row_bus;
  logic [11:0] rgb_bus;
  logic [7:0]  r_color, g_color, b_color;
  logic [3:0]  column;
  logic [3:0]  grant;
  logic        wrap_pulse;

  int    errors = 0;
  int    checks = 0;
  int    slot_len = 0;
  int    wrap_cnt = 0;
  slot_t exp_q[$];
  slot_t cur;
  slot_t obs;

  matrix_scan_arbiter #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK        (clk),
    .Clear      (clear),
    .enable     (enable),
    .req        (req),
    .col_bus    (col_bus),
    .row_bus    (row_bus),
    .rgb_bus    (rgb_bus),
    .R_color    (r_color),
    .G_color    (g_color),
    .B_color    (b_color),
    .column     (column),
    .grant      (grant),
    .wrap_pulse (wrap_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected slot contents computed from the bus values currently driven.
  function automatic slot_t make_slot(input int i);
    slot_t      s;
    logic [7:0] row;
    logic [2:0] rgb;
    row      = row_bus[8*i +: 8];
    rgb      = rgb_bus[3*i +: 3];
    s.grant  = 4'(1 << i);
    s.column = col_bus[4*i +: 4];
    s.r      = rgb[2] ? row : 8'hFF;
    s.g      = rgb[1] ? row : 8'hFF;
    s.b      = rgb[0] ? row : 8'hFF;
    return s;
  endfunction

  // Monitor: pops one expected slot per SHOW slot, checks every slot cycle
  // against it, the slot length and the wrap pulse after the slot.
  always @(negedge clk) begin
    obs = {grant, column, r_color, g_color, b_color};
    if (clear === 1'b1) begin
      slot_len = 0;
    end else if (grant !== 4'b0000) begin
      if (slot_len == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected: got %h, required no slot", obs);
          cur = obs;
        end else begin
          cur = exp_q.pop_front();
          if (obs !== cur) begin
            errors++;
            $display("FAIL slot_first: got %h, required %h", obs, cur);
          end
        end
      end else begin
        checks++;
        if (obs !== cur) begin
          errors++;
          $display("FAIL slot_hold: cycle %0d got %h, required %h", slot_len + 1, obs, cur);
        end
      end
      slot_len++;
    end else if (slot_len != 0) begin
      checks++;
      if (slot_len != DWELL) begin
        errors++;
        $display("FAIL slot_length: got %0d, required %0d", slot_len, DWELL);
      end
      checks++;
      if (wrap_pulse !== (cur.grant == 4'b1000)) begin
        errors++;
        $display("FAIL wrap_timing: got %b, required %b", wrap_pulse, (cur.grant == 4'b1000));
      end
      slot_len = 0;
    end
    if (clear !== 1'b1 && wrap_pulse === 1'b1) wrap_cnt++;
  end

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_popped(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL popped_%s: pending %0d, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && (exp_q.size() != 0 || slot_len != 0); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || slot_len != 0) begin
      errors++;
      $display("FAIL drain_%s: pending %0d slot_len %0d, required 0 and 0", name, exp_q.size(), slot_len);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    checks++; if (column !== 4'b0000) begin errors++; $display("FAIL reset_column: got %b, required 0000", column); end
    checks++; if (r_color !== 8'hFF) begin errors++; $display("FAIL reset_r: got %h, required FF", r_color); end
    checks++; if (g_color !== 8'hFF) begin errors++; $display("FAIL reset_g: got %h, required FF", g_color); end
    checks++; if (b_color !== 8'hFF) begin errors++; $display("FAIL reset_b: got %h, required FF", b_color); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b, required 0", wrap_pulse); end
  endtask

  task automatic test_single();
    do_clear();
    col_bus = 16'h000C;
    row_bus = 32'h0000_007F;
    rgb_bus = 12'b000_000_000_100;
    enable  = 1'b1;
    exp_q.push_back(make_slot(0));
    req = 4'b0001;
    @(posedge clk); @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL latency_edge1: got %b, required 0000", grant); end
    @(posedge clk); @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL latency_edge2: got %b, required 0001", grant); end
    checks++; if (r_color !== 8'h7F) begin errors++; $display("FAIL single_r: got %h, required 7F", r_color); end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++; if (column !== 4'b0000 || r_color !== 8'hFF || grant !== 4'b0000) begin
      errors++; $display("FAIL blank_outputs: got col=%b r=%h grant=%b, required 0000 FF 0000", column, r_color, grant);
    end
    wait_drain("single");
  endtask

  task automatic test_enable_gate();
    do_clear();
    enable = 1'b0;
    req    = 4'b0001;
    repeat (5) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL enable_low_grant: got %b, required 0000", grant); end
    exp_q.push_back(make_slot(0));
    enable = 1'b1;
    wait_popped("enable");
    enable = 1'b0;
    wait_drain("enable");
    repeat (8) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL enable_stop: got %b, required 0000", grant); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_clear();
    col_bus = 16'hBA98;
    row_bus = 32'h0F3C_55A5;
    rgb_bus = 12'b011_101_110_111;
    enable  = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(make_slot(i % 4));
    wrap_cnt = 0;
    req = 4'b1111;
    wait_popped("rr");
    req = 4'b0000;
    wait_drain("rr");
    checks++; if (wrap_cnt != 1) begin errors++; $display("FAIL wrap_count: got %0d, required 1", wrap_cnt); end
  endtask

  task automatic test_ineligible();
    do_clear();
    col_bus = 16'h060C;
    row_bus = 32'h0011_0022;
    rgb_bus = 12'b000_111_000_011;
    enable  = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(make_slot(0));
    req = 4'b0101;
    wait_popped("inelig");
    req = 4'b0000;
    wait_drain("inelig");
  endtask

  task automatic test_snapshot();
    do_clear();
    col_bus = 16'h000C;
    row_bus = 32'h0000_007F;
    rgb_bus = 12'b000_000_000_100;
    enable  = 1'b1;
    exp_q.push_back(make_slot(0));
    req = 4'b0001;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 row_bus = 32'h0000_0000; req = 4'b0000; col_bus = 16'h0000; rgb_bus = 12'h000;
    repeat (3) @(negedge clk);
    checks++; if (r_color !== 8'h7F) begin errors++; $display("FAIL snapshot_r: got %h, required 7F", r_color); end
    wait_drain("snap");
  endtask

  task automatic test_mid_reset();
    do_clear();
    col_bus = 16'hBA98;
    row_bus = 32'h0F3C_55A5;
    rgb_bus = 12'b011_101_110_111;
    enable  = 1'b1;
    exp_q.push_back(make_slot(0));
    req = 4'b1111;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (column !== 4'b0000 || grant !== 4'b0000 || r_color !== 8'hFF) begin
      errors++; $display("FAIL midreset_blank: got col=%b grant=%b r=%h, required 0000 0000 FF", column, grant, r_color);
    end
    exp_q.push_back(make_slot(0));
    clear = 1'b0;
    wait_popped("midreset");
    req = 4'b0000;
    wait_drain("midreset");
  endtask

  initial begin
    clear   = 1'b1;
    enable  = 1'b0;
    req     = 4'b0000;
    col_bus = 16'h0000;
    row_bus = 32'hFFFF_FFFF;
    rgb_bus = 12'h000;
    test_reset();
    test_single();
    test_enable_gate();
    test_round_robin();
    test_ineligible();
    test_snapshot();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
